// File: rtl/ro_meas_pkg.sv
// ---------------------------------------------------------------------------
// ro_meas_pkg
// Shared definitions for the ring-oscillator measurement stage: FSM state
// encoding, default widths/timing and the saturation limit of the default
// edge counter.
// ---------------------------------------------------------------------------
package ro_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } meas_state_t;

  localparam int DEF_GATE_W        = 16;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;

  // Largest value the default-width edge counter can hold.
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/ro_sync_edge.sv
// ---------------------------------------------------------------------------
// ro_sync_edge
// Brings the asynchronous oscillator tap into the clk domain through a
// SYNC_STAGES flop chain and flags rising edges of the synchronised level.
// The edge detector runs continuously so its history flop is always primed.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   async_in  in   oscillator tap, asynchronous to clk
//   s         out  synchronised tap level
//   rise      out  one-cycle pulse: s is 1 now and was 0 the cycle before
// ---------------------------------------------------------------------------
module ro_sync_edge
  import ro_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      // stage p0: synchroniser chain
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
      // stage p1: previous synchronised level
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~prev_p1;

endmodule

// File: rtl/ro_freq_counter.sv
// ---------------------------------------------------------------------------
// ro_freq_counter
// Enables the ring oscillator, waits SETTLE_CYCLES, then counts rising edges
// of its tap over gate_cycles clk cycles and returns the (saturating) count
// through a valid/ready handshake. One measurement per accepted start.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   start         in   single-cycle request, accepted only when idle
//   gate_cycles   in   window length, sampled on the accepted start
//   ro_tap        in   oscillator tap (asynchronous)
//   ro_enable     out  oscillator enable (SETTLE and COUNT)
//   busy          out  high whenever not idle
//   result        out  edge count of the last measurement
//   overflow      out  counter saturated during the last measurement
//   result_valid  out  result/overflow valid
//   result_ready  in   consumer accepts result
// ---------------------------------------------------------------------------
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int GATE_W        = DEF_GATE_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              ro_tap,
  output logic              ro_enable,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              overflow,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  // Returns {saturated, next_count}; the count sticks at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_SAT) begin
      return {1'b1, c};
    end
    return {1'b0, c + CNT_W'(1)};
  endfunction

  meas_state_t       state, state_nxt;
  logic [GATE_W-1:0] gate_q;
  logic [TMR_W-1:0]  timer, timer_nxt, gate_last;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W:0]    cnt_inc;
  logic              ovf, ovf_nxt;
  logic              load_result;
  logic              tap_s_unused;
  logic              tap_rise;

  ro_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (ro_tap),
    .s        (tap_s_unused),
    .rise     (tap_rise)
  );

  assign gate_last = TMR_W'(gate_q) - TMR_W'(1);
  assign cnt_inc   = sat_inc(cnt);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    load_result = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          timer_nxt = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          timer_nxt = '0;
          if (gate_q == '0) begin
            state_nxt   = ST_DONE;
            load_result = 1'b1;
          end else begin
            state_nxt = ST_COUNT;
          end
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_COUNT: begin
        if (tap_rise) begin
          cnt_nxt = cnt_inc[CNT_W-1:0];
          ovf_nxt = ovf | cnt_inc[CNT_W];
        end
        // The edge seen in the last window cycle is folded in via cnt_nxt.
        if (timer == gate_last) begin
          state_nxt   = ST_DONE;
          timer_nxt   = '0;
          load_result = 1'b1;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gate_q   <= '0;
      timer    <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      if (state == ST_IDLE && start) begin
        gate_q <= gate_cycles;
      end
      if (load_result) begin
        result   <= cnt_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

  assign ro_enable    = (state == ST_SETTLE) || (state == ST_COUNT);
  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_DONE);

endmodule
